// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester, memory port and status
//   signals of mem_port_arbiter.
//   slave  : arbiter side (drives grants, responses, memory command, status)
//   master : environment side (drives requests and memory responses)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rw;
  logic [1:0]        d_size;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              err_timeout;
  logic              err_spurious;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_addr, d_wdata, d_rw, d_size,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_addr, mem_wdata, mem_rw, mem_size,
    input  mem_rvalid, mem_rdata,
    output busy, err_timeout, err_spurious
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_addr, d_wdata, d_rw, d_size,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_rw, mem_size,
    output mem_rvalid, mem_rdata,
    input  busy, err_timeout, err_spurious
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one multi-cycle memory port between instruction fetch (IF) and
//   data load/store (D), one transaction outstanding at a time. D has
//   priority; after STARVE_LIMIT consecutive D grants with IF waiting, IF
//   wins. A transaction with no response for TIMEOUT wait cycles is
//   abandoned. Sticky error flags report timeouts and stray responses.
// Ports
//   clock, reset : clock; synchronous active-high reset
//   bus          : mem_port_arbiter_if.slave (requests, grants, responses,
//                  memory command/response, busy and error flags)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; arbitrate when any request is present
// ISSUE | one cycle: memory command strobe and grant pulse to the winner
// WAIT  | waiting for mem_rvalid; back-to-back arbitration on response
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 15
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = data side owns the transaction
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              err_to_q, err_to_d;
  logic              err_sp_q, err_sp_d;
  logic              arb, pick_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      tcnt_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      size_q   <= 2'b00;
      err_to_q <= 1'b0;
      err_sp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      tcnt_q   <= tcnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      err_to_q <= err_to_d;
      err_sp_q <= err_sp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    tcnt_d   = tcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    size_d   = size_q;
    err_to_d = err_to_q;
    // A response is only expected while waiting; anything else is stray.
    err_sp_d = err_sp_q | (bus.mem_rvalid & (state_q != S_WAIT));
    arb      = 1'b0;
    pick_d   = 1'b0;

    unique case (state_q)
      S_IDLE:  arb = bus.if_req | bus.d_req;
      S_ISSUE: begin
        state_d = S_WAIT;
        tcnt_d  = '0;
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          if (bus.if_req || bus.d_req) arb = 1'b1;
          else                         state_d = S_IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arb) begin
      state_d = S_ISSUE;
      pick_d  = bus.d_req & ~(bus.if_req & (streak_q == STREAK_MAX));
      owner_d = pick_d;
      if (pick_d) begin
        addr_d   = bus.d_addr;
        wdata_d  = bus.d_wdata;
        rw_d     = bus.d_rw;
        size_d   = bus.d_size;
        // Count only D wins that made a waiting fetch lose.
        if (!bus.if_req)                streak_d = '0;
        else if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
      end else begin
        addr_d   = bus.if_addr;
        wdata_d  = '0;
        rw_d     = 1'b0;
        size_d   = 2'b10;        // fetches are word reads
        streak_d = '0;
      end
    end
  end

  logic live, issue, rsp;
  assign live  = ~reset;
  assign issue = live & (state_q == S_ISSUE);
  assign rsp   = live & (state_q == S_WAIT) & bus.mem_rvalid;

  assign bus.mem_req      = issue;
  assign bus.if_gnt       = issue & ~owner_q;
  assign bus.d_gnt        = issue & owner_q;
  assign bus.if_rvalid    = rsp & ~owner_q;
  assign bus.d_rvalid     = rsp & owner_q;
  assign bus.if_rdata     = live ? bus.mem_rdata : '0;
  assign bus.d_rdata      = live ? bus.mem_rdata : '0;
  assign bus.busy         = live & (state_q != S_IDLE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_rw       = rw_q;
  assign bus.mem_size     = size_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.err_spurious = err_sp_q;
endmodule
